// File: rtl/bnn_load_sequencer.sv
// Sequencer for the 8-8-4 BNN: clears the core, streams weight bytes as nibble pairs,
// and runs single inferences with a fixed settle time. Loads and inferences are mutually exclusive.
module bnn_load_sequencer #(
    parameter int unsigned NUM_NEURONS   = 12,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       infer_req,
    input  logic [7:0] x_in,
    output logic       bnn_clr,
    output logic       load_en,
    output logic [3:0] load_nibble,
    output logic [7:0] bnn_x,
    input  logic [3:0] bnn_y,
    output logic [3:0] y_out,
    output logic       y_valid,
    output logic       busy,
    output logic       loaded,
    output logic [3:0] neuron_idx,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_BYTE,
        S_LO,
        S_HI,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    localparam logic [3:0]  LAST_IDX    = 4'(NUM_NEURONS - 1);
    localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  buf_q, buf_d;
    logic [3:0]  idx_q, idx_d;
    logic        loaded_q, loaded_d;
    logic        err_q, err_d;
    logic [7:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            idx_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;

        if ((state_q != S_IDLE) && (start || infer_req)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end else if (infer_req) begin
                    x_d     = x_in;
                    cnt_d   = SETTLE_INIT;
                    state_d = S_SETTLE;
                end
            end
            S_CLEAR: begin
                idx_d    = '0;
                loaded_d = 1'b0;
                state_d  = S_WAIT_BYTE;
            end
            S_WAIT_BYTE: begin
                if (in_valid) begin
                    buf_d   = in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                state_d = S_HI;
            end
            S_HI: begin
                if (idx_q == LAST_IDX) begin
                    loaded_d = 1'b1;
                    idx_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_WAIT_BYTE;
                end
            end
            S_SETTLE: begin
                // Sample on the edge entering CAPTURE so y_out is already valid while y_valid is high.
                if (cnt_q == '0) begin
                    y_d     = bnn_y;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        load_nibble = '0;
        if (state_q == S_LO) begin
            load_nibble = buf_q[3:0];
        end else if (state_q == S_HI) begin
            load_nibble = buf_q[7:4];
        end
    end

    assign bnn_clr    = (state_q == S_CLEAR);
    assign load_en    = (state_q == S_LO) || (state_q == S_HI);
    assign in_ready   = (state_q == S_WAIT_BYTE);
    assign y_valid    = (state_q == S_CAPTURE);
    assign busy       = (state_q != S_IDLE);
    assign bnn_x      = x_q;
    assign y_out      = y_q;
    assign loaded     = loaded_q;
    assign neuron_idx = idx_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bnn_load_sequencer.sv
// Scoreboard bench for bnn_load_sequencer, driving a behavioural 8-8-4 BNN core model.
module tb_bnn_load_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, in_valid, infer_req;
    logic [7:0] in_data, x_in;
    logic       in_ready, bnn_clr, load_en, y_valid, busy, loaded, err;
    logic [3:0] load_nibble, bnn_y, y_out, neuron_idx;
    logic [7:0] bnn_x;

    always #5 clk = ~clk;

    bnn_load_sequencer #(.NUM_NEURONS(12), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .infer_req(infer_req), .x_in(x_in), .bnn_clr(bnn_clr),
        .load_en(load_en), .load_nibble(load_nibble), .bnn_x(bnn_x), .bnn_y(bnn_y),
        .y_out(y_out), .y_valid(y_valid), .busy(busy), .loaded(loaded),
        .neuron_idx(neuron_idx), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int clr_cnt = 0;
    int en_cnt = 0;
    logic [3:0] exp_nib[$];
    logic [3:0] exp_y[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] dflt(input int i);
        return 8'h5A ^ 8'(i * 17);
    endfunction

    function automatic logic [3:0] ref_y(input logic [95:0] wv, input logic [7:0] x);
        logic [7:0] h;
        logic [3:0] y;
        for (int j = 0; j < 8; j++) h[j] = ($countones(~(x ^ wv[j*8 +: 8])) >= 4);
        for (int k = 0; k < 4; k++) y[k] = ($countones(~(h ^ wv[(8+k)*8 +: 8])) >= 4);
        return y;
    endfunction

    // Behavioural BNN core: first enable latches the low nibble, second writes the weight.
    logic [95:0] w;
    logic [3:0]  ptr, lo;
    logic        ph;
    always @(posedge clk or posedge reset) begin
        if (reset || bnn_clr) begin
            for (int i = 0; i < 12; i++) w[i*8 +: 8] <= dflt(i);
            ptr <= '0;
            ph  <= 1'b0;
        end else if (load_en) begin
            if (!ph) begin
                lo <= load_nibble;
                ph <= 1'b1;
            end else begin
                w[int'(ptr)*8 +: 8] <= {load_nibble, lo};
                ptr <= ptr + 4'd1;
                ph  <= 1'b0;
            end
        end
    end
    assign bnn_y = ref_y(w, bnn_x);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bnn_clr) clr_cnt++;
            if (load_en) begin
                en_cnt++;
                if (exp_nib.size() == 0) chk("nibble_unexpected", 1, 0);
                else chk("nibble", load_nibble, exp_nib.pop_front());
            end
            if (y_valid) begin
                if (exp_y.size() == 0) chk("y_valid_unexpected", 1, 0);
                else chk("y_out", y_out, exp_y.pop_front());
            end
        end
    end

    task automatic do_load(input logic [95:0] b, input int gap, input bit with_infer,
                           input int infer_at, input int abort_at);
        int c0, n;
        @(negedge clk);
        start = 1'b1;
        if (with_infer) begin
            infer_req = 1'b1;
            x_in = 8'h77;
        end
        for (int i = 0; i < 12; i++) begin
            exp_nib.push_back(b[i*8 +: 4]);
            exp_nib.push_back(b[i*8+4 +: 4]);
        end
        clr_cnt = 0;
        en_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        infer_req = 1'b0;
        c0 = cyc;
        chk("clr_pulse", bnn_clr, 1);
        chk("busy_clear", busy, 1);
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("gap_in_ready", in_ready, 1);
                chk("gap_load_en", load_en, 0);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data = b[i*8 +: 8];
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n == 50) chk("ready_timeout", 0, 1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            if (i == infer_at) begin
                infer_req = 1'b1;
                x_in = 8'h3C;
            end
            @(negedge clk);
            infer_req = 1'b0;
            chk("idx_in_hi", neuron_idx, i);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", busy, 0);      chk("rst_clr", bnn_clr, 0);
                chk("rst_load_en", load_en, 0); chk("rst_nibble", load_nibble, 0);
                chk("rst_in_ready", in_ready, 0); chk("rst_bnn_x", bnn_x, 0);
                chk("rst_y_out", y_out, 0);    chk("rst_y_valid", y_valid, 0);
                chk("rst_loaded", loaded, 0);  chk("rst_idx", neuron_idx, 0);
                chk("rst_err", err, 0);
                chk("rst_bnn_defaults", w[63:56], dflt(7));
                exp_nib.delete();
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end
        chk("busy_last_hi", busy, 1);
        chk("loaded_last_hi", loaded, 0);
        @(negedge clk);
        chk("busy_done", busy, 0);
        chk("loaded_done", loaded, 1);
        chk("idx_wrap", neuron_idx, 0);
        if (gap == 0) chk("load_cycles", cyc - c0 + 1, 38);
        chk("clr_count", clr_cnt, 1);
        chk("load_en_count", en_cnt, 24);
        chk("nibbles_left", exp_nib.size(), 0);
    endtask

    task automatic do_infer(input logic [95:0] wexp, input logic [7:0] x);
        @(negedge clk);
        infer_req = 1'b1;
        x_in = x;
        exp_y.push_back(ref_y(wexp, x));
        @(posedge clk);
        @(negedge clk);
        infer_req = 1'b0;
        chk("bnn_x", bnn_x, x);
        chk("busy_settle", busy, 1);
        chk("y_valid_early", y_valid, 0);
        @(negedge clk);
        chk("y_valid_pulse", y_valid, 1);
        @(negedge clk);
        chk("y_valid_after", y_valid, 0);
        chk("busy_after_infer", busy, 0);
        chk("y_out_hold", y_out, ref_y(wexp, x));
        chk("y_left", exp_y.size(), 0);
    endtask

    logic [95:0] tbl_a, tbl_b;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 12; i++) tbl_a[i*8 +: 8] = 8'(i);
        tbl_b = {8'hC3, 8'h3C, 8'hF0, 8'h0F, 8'h81, 8'hAA, 8'h55, 8'hCC, 8'h33, 8'hF0, 8'h0F, 8'hFF};
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; infer_req = 1'b0;
        in_data = '0; x_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("init_busy", busy, 0);       chk("init_clr", bnn_clr, 0);
        chk("init_load_en", load_en, 0); chk("init_nibble", load_nibble, 0);
        chk("init_in_ready", in_ready, 0); chk("init_bnn_x", bnn_x, 0);
        chk("init_y_out", y_out, 0);     chk("init_y_valid", y_valid, 0);
        chk("init_loaded", loaded, 0);   chk("init_idx", neuron_idx, 0);
        chk("init_err", err, 0);

        do_load(tbl_a, 0, 1'b0, -1, -1);
        chk("weights_a", w, tbl_a);
        chk("err_clean", err, 0);

        do_load(tbl_b, 0, 1'b1, -1, -1);
        chk("err_simultaneous", err, 0);
        chk("bnn_x_simultaneous", bnn_x, 0);
        chk("weights_b", w, tbl_b);

        do_infer(tbl_b, 8'hFF);

        do_load(tbl_a, 5, 1'b0, 5, -1);
        chk("err_during_load", err, 1);
        chk("bnn_x_kept", bnn_x, 8'hFF);
        chk("weights_gap", w, tbl_a);
        do_infer(tbl_a, 8'h96);

        do_load(tbl_b, 0, 1'b0, -1, 7);
        do_load(tbl_b, 0, 1'b0, -1, -1);
        chk("weights_reload", w, tbl_b);
        do_infer(tbl_b, 8'h5A);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
